// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//   Responder side of the cache control interface. Accepts word reads and
//   writes from the dcache and word reads from the icache. It forwards one
//   request at a time to a single-ported RAM, and the dcache has priority.
//   A completed word is signalled by dropping the owning requester's wait
//   line for exactly one cycle.
//
// Ports
//   CLK, RST              clock; synchronous active-high reset
//   iREN, iaddr           icache read request and word address
//   iwait, iload          icache wait (0 = done) and read data
//   dREN, dWEN            dcache read / write request (write wins)
//   daddr, dstore         dcache word address and write data
//   dwait, dload          dcache wait (0 = done) and read data
//   ramREN, ramWEN        RAM read / write strobes
//   ramaddr, ramstore     RAM address and write data
//   ramload, ramready     RAM read data and access-complete flag
//   busy                  high whenever the responder is not idle
module cache_mem_responder #(
    parameter int MIN_LAT = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [31:0]       iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       dstore,
    output logic              dwait,
    output logic [31:0]       dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic              ramready,
    output logic              busy
);

    localparam int CNT_W = $clog2(MIN_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    state_t            state_q,   state_d;
    owner_t            owner_q,   owner_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              op_q,      op_d;      // 1 = write
    logic [31:0]       data_q,    data_d;
    logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0]       load_q,    load_d;

    // Live view of whatever the current owner is presenting right now.
    logic              own_active;
    logic [ADDR_W-1:0] own_addr;
    logic              own_op;

    always_comb begin
        own_active = 1'b0;
        own_addr   = '0;
        own_op     = 1'b0;
        case (owner_q)
            OWN_D: begin
                own_active = dREN | dWEN;
                own_addr   = daddr;
                own_op     = dWEN;
            end
            OWN_I: begin
                own_active = iREN;
                own_addr   = iaddr;
                own_op     = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        op_d      = op_q;
        data_d    = data_q;
        lat_cnt_d = lat_cnt_q;
        load_d    = load_q;

        case (state_q)
            IDLE: begin
                lat_cnt_d = '0;
                load_d    = '0;
                owner_d   = OWN_NONE;
                if (dREN | dWEN) begin
                    owner_d = OWN_D;
                    addr_d  = daddr;
                    op_d    = dWEN;
                    data_d  = dstore;
                    state_d = ACCESS;
                end else if (iREN) begin
                    owner_d = OWN_I;
                    addr_d  = iaddr;
                    op_d    = 1'b0;
                    data_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!own_active) begin
                    // Owner gave up: abandon silently.
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end else if (own_addr != addr_q || own_op != op_q) begin
                    // Owner moved to a different access: start it over.
                    addr_d    = own_addr;
                    op_d      = own_op;
                    data_d    = (owner_q == OWN_D) ? dstore : '0;
                    lat_cnt_d = '0;
                end else begin
                    if (lat_cnt_q != CNT_W'(MIN_LAT))
                        lat_cnt_d = lat_cnt_q + 1'b1;
                    if (ramready && lat_cnt_q >= CNT_W'(MIN_LAT - 1)) begin
                        load_d  = op_q ? 32'h0 : ramload;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            addr_q    <= '0;
            op_q      <= 1'b0;
            data_q    <= '0;
            lat_cnt_q <= '0;
            load_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            data_q    <= data_d;
            lat_cnt_q <= lat_cnt_d;
            load_q    <= load_d;
        end
    end

    // Outputs depend only on registered state, never on live inputs.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        busy     = (state_q != IDLE);
        case (state_q)
            ACCESS: begin
                ramREN   = ~op_q;
                ramWEN   = op_q;
                ramaddr  = addr_q;
                ramstore = data_q;
            end
            DONE: begin
                if (owner_q == OWN_D) begin
                    dwait = 1'b0;
                    dload = load_q;
                end else if (owner_q == OWN_I) begin
                    iwait = 1'b0;
                    iload = load_q;
                end
            end
            default: ;
        endcase
    end

endmodule
